trws_sweep_scheduler: RTL and testbench
=======================================

// Module: trws_sweep_scheduler
// PURPOSE
//  Sequences sequencial_message_passer over a full IMG_W x IMG_H grid for TRW-S inference.
//  Each iteration is a forward raster sweep (addr 0..N-1) followed by a backward sweep (N-1..0).
//  Per pixel, the block issues memory reads and then push, with direction and border flags, to the passer.
//  It returns write-back addresses in order on passer valid, and drains between sweeps to avoid RAW hazards.
// PARAMETERS
//  IMG_W        64  pixels per row
//  IMG_H        48  rows
//  ADDR_WIDTH   12  pixel address width; must satisfy 2**ADDR_WIDTH >= IMG_W*IMG_H
//  ITER_WIDTH    8  width of iteration count
//  RD_LAT        2  cycles from rd_en to message/data-cost read data valid
//  MAX_INFLIGHT 16  max pixels issued but not yet returned; power of 2, >=2
// PORTS
//  clk         in   1           clock, all state on posedge
//  rst         in   1           asynchronous, active-high reset
//  start       in   1           begin run; sampled only in IDLE
//  num_iters   in   ITER_WIDTH  iterations to run; sampled with start
//  stall       in   1           memory backpressure; blocks new issue
//  rd_en       out  1           read message/data-cost memories at rd_addr
//  rd_addr     out  ADDR_WIDTH  pixel address being read
//  push        out  1           to passer push; rd_en delayed RD_LAT
//  sweep_dir   out  1           0=forward 1=backward, aligned with push
//  border      out  4           {first_row,last_row,first_col,last_col}, aligned with push
//  valid       in   1           from passer valid (results in issue order)
//  wr_en       out  1           write passer outputs back
//  wr_addr     out  ADDR_WIDTH  write-back pixel address
//  wr_dir      out  1           sweep direction of the written result
//  busy        out  1           high outside IDLE
//  done        out  1           one-cycle pulse at run completion
//  iter_count  out  ITER_WIDTH  completed iterations this run
//  error       out  1           sticky: valid received with empty address queue
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters/queue/delay line cleared. Reset mid-run aborts with no done pulse.
//  FSM: IDLE -> FWD -> FWD_DRAIN -> BWD -> BWD_DRAIN -> (FWD | IDLE).
//   IDLE: start&&num_iters!=0 -> FWD, iter_count<=0, error<=0, addr<=0.
//     start&&num_iters==0 -> done pulse next cycle, stay IDLE. start while busy is ignored.
//   FWD: issue = !stall && inflight<MAX_INFLIGHT; on issue, rd_en=1 and addr++.
//     The last issue, at addr N-1, moves the FSM to FWD_DRAIN.
//   FWD_DRAIN: when inflight==0 && !valid -> BWD, addr<=N-1.
//   BWD: as FWD with addr--; the issue at addr 0 moves the FSM to BWD_DRAIN.
//   BWD_DRAIN: when drained, iter_count++. If the new count==num_iters -> IDLE with done=1 for one cycle; else -> FWD, addr<=0.
//  Address generation uses row/col counters; col wraps at IMG_W-1, so no multiplier.
//  border is computed from the row/col counters at issue time.
//  rd_en is registered; rd_addr holds its value while stalled.
//  push/sweep_dir/border = RD_LAT-stage delay line of {rd_en,dir,border}.
//  inflight: +1 on issue, -1 on valid, unchanged when both occur in the same cycle. Range 0..MAX_INFLIGHT, no wrap.
//  Addr queue: {dir,addr} pushed on issue, popped on valid. Depth MAX_INFLIGHT, so it never overflows.
//  Write-back: wr_en/wr_addr/wr_dir are registered, 1 cycle after valid.
//  valid with empty queue: ignored (no wr_en), inflight stays 0, error<=1. Cleared only by rst or an accepted start.
//  Passer latency is arbitrary but in-order; throughput is 1 pixel/cycle when latency+RD_LAT < MAX_INFLIGHT.
// STRUCTURE
//  trws_pkg holds FSM state localparams, border bit indices (BR_FIRST_ROW=3..BR_LAST_COL=0), DIR_FWD/DIR_BWD.
//  Sub-module trws_addr_fifo: sync FIFO, width ADDR_WIDTH+1, depth MAX_INFLIGHT, async reset, full/empty flags.
//  Top level holds the FSM, row/col counters, inflight counter and RD_LAT delay line.
// TESTING (IMG_W=4, IMG_H=3, RD_LAT=2, MAX_INFLIGHT=4; behavioral passer, fixed latency L)
//  1 num_iters=1, L=3 -> rd_addr 0..11 then 11..0, each push 2 cycles after rd_en.
//    border=4'b1010 at fwd addr 0 and 4'b0101 at addr 11.
//    24 wr_en in issue order, iter_count=1, exactly one done pulse.
//  2 L=10 -> inflight never >4. First BWD rd_en occurs only after wr_en for fwd addr 11. No push lost.
//  3 stall high for 5 cycles while rd_addr=5 -> rd_en=0, rd_addr stays 5. Next issue is addr 6; write order intact.
//  4 num_iters=0 -> done one cycle later, no rd_en.
//    num_iters=3 -> 72 writes, iter_count=3, busy low after done.
//  5 rst asserted while FWD addr=7 -> all outputs 0 immediately. A stale valid then gives error=1 and wr_en=0.
//    A new start clears error and restarts at addr 0.
//  6 inflight=3 with issue and valid in the same cycle -> inflight stays 3.
//    The queue never reports full+push, and wr_addr matches the popped entry.

Source files
------------

// File: rtl/trws_pkg.sv
// rtl/trws_pkg.sv - shared types and constants for the TRW-S sweep scheduler
// Purpose: FSM state encoding, border flag bit positions, sweep direction codes
//   and a helper that packs the four border flags.
// Ports: none (package)
package trws_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FWD       = 3'd1,
      ST_FWD_DRAIN = 3'd2,
      ST_BWD       = 3'd3,
      ST_BWD_DRAIN = 3'd4
   } state_e;

   localparam int BORDER_W     = 4;
   localparam int BR_FIRST_ROW = 3;
   localparam int BR_LAST_ROW  = 2;
   localparam int BR_FIRST_COL = 1;
   localparam int BR_LAST_COL  = 0;

   localparam logic DIR_FWD = 1'b0;
   localparam logic DIR_BWD = 1'b1;

   function automatic logic [BORDER_W-1:0] make_border(input logic first_row,
                                                       input logic last_row,
                                                       input logic first_col,
                                                       input logic last_col);
      logic [BORDER_W-1:0] b;
      b               = '0;
      b[BR_FIRST_ROW] = first_row;
      b[BR_LAST_ROW]  = last_row;
      b[BR_FIRST_COL] = first_col;
      b[BR_LAST_COL]  = last_col;
      return b;
   endfunction

endpackage

// File: rtl/trws_sweep_scheduler_if.sv
// rtl/trws_sweep_scheduler_if.sv - control, memory-read, passer and write-back bundle
// Purpose: groups every non-clock/reset signal of the sweep scheduler.
// Ports (as seen from the master = scheduler):
//   in : start, num_iters, stall, valid
//   out: rd_en, rd_addr, push, sweep_dir, border, wr_en, wr_addr, wr_dir,
//        busy, done, iter_count, error
// The slave modport is the environment side (controller, memories, passer).
interface trws_sweep_scheduler_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int ITER_WIDTH = 8
);
   logic                  start;
   logic [ITER_WIDTH-1:0] num_iters;
   logic                  stall;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  push;
   logic                  sweep_dir;
   logic [3:0]            border;
   logic                  valid;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic                  wr_dir;
   logic                  busy;
   logic                  done;
   logic [ITER_WIDTH-1:0] iter_count;
   logic                  error;

   modport master (
      input  start, num_iters, stall, valid,
      output rd_en, rd_addr, push, sweep_dir, border,
             wr_en, wr_addr, wr_dir, busy, done, iter_count, error
   );

   modport slave (
      output start, num_iters, stall, valid,
      input  rd_en, rd_addr, push, sweep_dir, border,
             wr_en, wr_addr, wr_dir, busy, done, iter_count, error
   );
endinterface

// File: rtl/trws_addr_fifo.sv
// rtl/trws_addr_fifo.sv - synchronous FIFO holding {dir,addr} of in-flight pixels
// Purpose: remembers issued pixel addresses so passer results are written back
//   in issue order.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push_i        write push_data_i (ignored when full)
//   push_data_i   entry to store
//   pop_i         drop the head entry (ignored when empty)
//   pop_data_o    current head entry
//   full_o        DEPTH entries stored
//   empty_o       no entries stored
module trws_addr_fifo #(
   parameter int WIDTH = 13,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_data_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int PW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit to tell full from empty.
   logic [PW:0]      wr_ptr_q;
   logic [PW:0]      rd_ptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic do_push;
   logic do_pop;

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   assign empty_o    = (wr_ptr_q == rd_ptr_q);
   assign full_o     = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                       (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign pop_data_o = mem_q[rd_ptr_q[PW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_data_i;
   end

endmodule

// File: rtl/trws_sweep_scheduler.sv
// rtl/trws_sweep_scheduler.sv - TRW-S forward/backward raster sweep scheduler
// Purpose: for num_iters iterations walks the IMG_W x IMG_H grid forward
//   (0..N-1) then backward (N-1..0), issuing memory reads, pushing pixels to the
//   message passer RD_LAT cycles later with direction/border flags, and writing
//   results back in issue order. Drains all in-flight pixels between sweeps so a
//   sweep never reads a message the previous sweep has not yet written.
// Ports:
//   clk  clock, all state on posedge
//   rst  asynchronous active-high reset
//   bus  master side of trws_sweep_scheduler_if
module trws_sweep_scheduler #(
   parameter int IMG_W        = 64,
   parameter int IMG_H        = 48,
   parameter int ADDR_WIDTH   = 12,
   parameter int ITER_WIDTH   = 8,
   parameter int RD_LAT       = 2,
   parameter int MAX_INFLIGHT = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   trws_sweep_scheduler_if.master bus
);
   import trws_pkg::*;

   localparam int NPIX   = IMG_W * IMG_H;
   localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int INFL_W = $clog2(MAX_INFLIGHT) + 1;
   localparam int DLY_W  = 2 + BORDER_W;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NPIX - 1);
   localparam logic [ROW_W-1:0]      LAST_ROW  = ROW_W'(IMG_H - 1);
   localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(IMG_W - 1);
   localparam logic [INFL_W-1:0]     INFL_MAX  = INFL_W'(MAX_INFLIGHT);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ROW_W-1:0]      row_q;
   logic [COL_W-1:0]      col_q;
   logic [INFL_W-1:0]     inflight_q;
   logic [ITER_WIDTH-1:0] iter_count_q;
   logic [ITER_WIDTH-1:0] num_iters_q;
   logic                  done_q, done_d;
   logic                  error_q;

   logic                  rd_en_q;
   logic [ADDR_WIDTH-1:0] rd_addr_q;
   logic                  rd_dir_q;
   logic [BORDER_W-1:0]   rd_border_q;
   logic [DLY_W-1:0]      dly_q [RD_LAT];

   logic                  wr_en_q;
   logic [ADDR_WIDTH-1:0] wr_addr_q;
   logic                  wr_dir_q;

   logic                  can_issue;
   logic                  issue;
   logic                  drained;
   logic                  pop_ok;
   logic                  stale_valid;
   logic                  run_start;
   logic                  load_fwd;
   logic                  load_bwd;
   logic                  iter_inc;
   logic                  issue_dir;
   logic [BORDER_W-1:0]   border_c;

   logic                  fifo_full;
   logic                  fifo_empty;
   logic [ADDR_WIDTH:0]   fifo_dout;

   // A valid with nothing queued has no address to write to; it is dropped.
   assign pop_ok      = bus.valid && !fifo_empty;
   assign stale_valid = bus.valid && fifo_empty;
   assign can_issue   = !bus.stall && (inflight_q < INFL_MAX) && !fifo_full;
   assign drained     = (inflight_q == '0) && !bus.valid;
   assign issue_dir   = (state_q == ST_BWD) ? DIR_BWD : DIR_FWD;
   assign border_c    = make_border(row_q == '0, row_q == LAST_ROW,
                                    col_q == '0, col_q == LAST_COL);

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      issue     = 1'b0;
      run_start = 1'b0;
      load_fwd  = 1'b0;
      load_bwd  = 1'b0;
      iter_inc  = 1'b0;
      done_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               run_start = 1'b1;
               if (bus.num_iters != '0) begin
                  state_d  = ST_FWD;
                  load_fwd = 1'b1;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ST_FWD: begin
            if (can_issue) begin
               issue = 1'b1;
               if (addr_q == LAST_ADDR) state_d = ST_FWD_DRAIN;
            end
         end
         ST_FWD_DRAIN: begin
            if (drained) begin
               state_d  = ST_BWD;
               load_bwd = 1'b1;
            end
         end
         ST_BWD: begin
            if (can_issue) begin
               issue = 1'b1;
               if (addr_q == '0) state_d = ST_BWD_DRAIN;
            end
         end
         ST_BWD_DRAIN: begin
            if (drained) begin
               iter_inc = 1'b1;
               if ((iter_count_q + ITER_WIDTH'(1)) == num_iters_q) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d  = ST_FWD;
                  load_fwd = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- run bookkeeping ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iter_count_q <= '0;
         num_iters_q  <= '0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         done_q <= done_d;
         if (run_start) begin
            iter_count_q <= '0;
            num_iters_q  <= bus.num_iters;
         end else if (iter_inc) begin
            iter_count_q <= iter_count_q + ITER_WIDTH'(1);
         end
         // A stale valid in the same cycle as a start still flags the error.
         if (stale_valid)    error_q <= 1'b1;
         else if (run_start) error_q <= 1'b0;
      end
   end

   // ---------------- address / row / col counters ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q <= '0;
         row_q  <= '0;
         col_q  <= '0;
      end else if (load_fwd) begin
         addr_q <= '0;
         row_q  <= '0;
         col_q  <= '0;
      end else if (load_bwd) begin
         addr_q <= LAST_ADDR;
         row_q  <= LAST_ROW;
         col_q  <= LAST_COL;
      end else if (issue) begin
         // Counters step past the grid edge after the final issue of a sweep;
         // the drain state reloads them before they are used again.
         if (issue_dir == DIR_FWD) begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
            if (col_q == LAST_COL) begin
               col_q <= '0;
               row_q <= row_q + ROW_W'(1);
            end else begin
               col_q <= col_q + COL_W'(1);
            end
         end else begin
            addr_q <= addr_q - ADDR_WIDTH'(1);
            if (col_q == '0) begin
               col_q <= LAST_COL;
               row_q <= row_q - ROW_W'(1);
            end else begin
               col_q <= col_q - COL_W'(1);
            end
         end
      end
   end

   // ---------------- in-flight counter ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_q <= '0;
      end else if (issue && !pop_ok) begin
         inflight_q <= inflight_q + INFL_W'(1);
      end else if (!issue && pop_ok) begin
         inflight_q <= inflight_q - INFL_W'(1);
      end
   end

   // ---------------- read issue and push delay line ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_en_q     <= 1'b0;
         rd_addr_q   <= '0;
         rd_dir_q    <= 1'b0;
         rd_border_q <= '0;
      end else begin
         rd_en_q <= issue;
         if (issue) begin
            rd_addr_q   <= addr_q;
            rd_dir_q    <= issue_dir;
            rd_border_q <= border_c;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) dly_q[i] <= '0;
      end else begin
         dly_q[0] <= {rd_en_q, rd_dir_q, rd_border_q};
         for (int i = 1; i < RD_LAT; i++) dly_q[i] <= dly_q[i-1];
      end
   end

   // ---------------- address queue and write-back ----------------
   trws_addr_fifo #(
      .WIDTH (ADDR_WIDTH + 1),
      .DEPTH (MAX_INFLIGHT)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (issue),
      .push_data_i ({issue_dir, addr_q}),
      .pop_i       (pop_ok),
      .pop_data_o  (fifo_dout),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_dir_q  <= 1'b0;
      end else begin
         wr_en_q <= pop_ok;
         if (pop_ok) {wr_dir_q, wr_addr_q} <= fifo_dout;
      end
   end

   // ---------------- outputs ----------------
   assign bus.rd_en      = rd_en_q;
   assign bus.rd_addr    = rd_addr_q;
   assign bus.push       = dly_q[RD_LAT-1][DLY_W-1];
   assign bus.sweep_dir  = dly_q[RD_LAT-1][BORDER_W];
   assign bus.border     = dly_q[RD_LAT-1][BORDER_W-1:0];
   assign bus.wr_en      = wr_en_q;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.wr_dir     = wr_dir_q;
   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.done       = done_q;
   assign bus.iter_count = iter_count_q;
   assign bus.error      = error_q;

endmodule

// File: tb/tb_trws_sweep_scheduler.sv
// tb/tb_trws_sweep_scheduler.sv - directed self-checking bench for trws_sweep_scheduler
module tb_trws_sweep_scheduler;
   localparam int IMG_W = 4;
   localparam int IMG_H = 3;
   localparam int NPIX  = 12;
   localparam int AW    = 4;
   localparam int IW    = 8;
   localparam int RDL   = 2;
   localparam int MAXF  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   trws_sweep_scheduler_if #(.ADDR_WIDTH(AW), .ITER_WIDTH(IW)) bif ();

   trws_sweep_scheduler #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_WIDTH(AW), .ITER_WIDTH(IW),
      .RD_LAT(RDL), .MAX_INFLIGHT(MAXF)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   // Behavioral passer: fixed latency lat from push to valid, in order.
   int          lat = 3;
   logic [31:0] vpipe;
   logic        inj_valid = 1'b0;
   always @(posedge clk or posedge rst) begin
      if (rst) vpipe <= '0;
      else     vpipe <= {vpipe[30:0], bif.push};
   end
   assign bif.valid = vpipe[lat-1] | inj_valid;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor
   int              cyc = 0;
   logic [AW-1:0]   rd_q[$];
   logic [AW:0]     wr_q[$];
   int              rd_cyc[$];
   int              wr_cyc[$];
   int              done_cnt = 0;
   int              push_cnt = 0;
   int              push_bad = 0;
   int              max_infl = 0;
   int              same_seen = 0;
   int              same_bad = 0;
   logic            same_pend = 1'b0;
   int              fullpush = 0;
   logic            rh0 = 1'b0, rh1 = 1'b0;
   logic [AW-1:0]   ah0 = '0, ah1 = '0;
   logic [3:0]      pb_border [2][16];

   always @(negedge clk) begin
      cyc++;
      if (bif.rd_en) begin
         rd_q.push_back(bif.rd_addr);
         rd_cyc.push_back(cyc);
      end
      if (bif.push !== rh1) push_bad++;
      if (bif.push) begin
         push_cnt++;
         pb_border[bif.sweep_dir][ah1] = bif.border;
      end
      rh1 = rh0; rh0 = bif.rd_en;
      ah1 = ah0; ah0 = bif.rd_addr;
      if (bif.wr_en) begin
         wr_q.push_back({bif.wr_dir, bif.wr_addr});
         wr_cyc.push_back(cyc);
      end
      if (bif.done) done_cnt++;
      if (int'(dut.inflight_q) > max_infl) max_infl = int'(dut.inflight_q);
      if (same_pend) begin
         same_seen++;
         if (dut.inflight_q != 3) same_bad++;
      end
      same_pend = (dut.inflight_q == 3) && dut.issue && dut.pop_ok;
      if (dut.u_fifo.full_o && dut.u_fifo.push_i) fullpush++;
   end

   task automatic clear_logs();
      rd_q.delete(); wr_q.delete(); rd_cyc.delete(); wr_cyc.delete();
      push_cnt = 0; push_bad = 0; max_infl = 0;
      same_seen = 0; same_bad = 0; same_pend = 1'b0;
      for (int d = 0; d < 2; d++)
         for (int a = 0; a < 16; a++) pb_border[d][a] = 4'hF;
   endtask

   task automatic start_run(input int iters, input int l);
      lat = l;
      clear_logs();
      @(posedge clk); #1;
      bif.num_iters = IW'(iters);
      bif.start     = 1'b1;
      @(posedge clk); #1;
      bif.start     = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (!bif.done && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done_seen"}, bif.done, 1'b1);
   endtask

   // Expected: per iteration addresses 0..11 then 11..0; writes carry dir.
   task automatic cmp_logs(input string tag, input int iters);
      int tot = 2 * NPIX * iters;
      check({tag, "_rd_count"}, rd_q.size(), tot);
      check({tag, "_wr_count"}, wr_q.size(), tot);
      for (int i = 0; i < tot; i++) begin
         int k = i % (2 * NPIX);
         logic [AW-1:0] ea = (k < NPIX) ? AW'(k) : AW'(2 * NPIX - 1 - k);
         logic [AW:0]   ew = {(k >= NPIX), ea};
         if (i < rd_q.size()) check($sformatf("%s_rd[%0d]", tag, i), rd_q[i], ea);
         if (i < wr_q.size()) check($sformatf("%s_wr[%0d]", tag, i), wr_q[i], ew);
      end
   endtask

   initial begin
      int d0;
      int n;
      bif.start = 1'b0; bif.num_iters = '0; bif.stall = 1'b0;
      clear_logs();

      // Reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_rd_en", bif.rd_en, 0);
      check("rst_push", bif.push, 0);
      check("rst_wr_en", bif.wr_en, 0);
      check("rst_busy", bif.busy, 0);
      check("rst_done", bif.done, 0);
      check("rst_error", bif.error, 0);
      check("rst_iter", bif.iter_count, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // 1: single iteration, L=3
      d0 = done_cnt;
      start_run(1, 3);
      check("t1_busy", bif.busy, 1);
      wait_done("t1", 2000);
      repeat (5) @(negedge clk);
      cmp_logs("t1", 1);
      check("t1_push_cnt", push_cnt, 24);
      check("t1_push_align", push_bad, 0);
      check("t1_border_f0", pb_border[0][0], 4'b1010);
      check("t1_border_f11", pb_border[0][11], 4'b0101);
      check("t1_border_b4", pb_border[1][4], 4'b0010);
      check("t1_border_b5", pb_border[1][5], 4'b0000);
      check("t1_border_b11", pb_border[1][11], 4'b0101);
      check("t1_iter", bif.iter_count, 1);
      check("t1_done_once", done_cnt - d0, 1);
      check("t1_busy_end", bif.busy, 0);

      // 2: long passer latency
      start_run(1, 10);
      wait_done("t2", 4000);
      repeat (3) @(negedge clk);
      cmp_logs("t2", 1);
      check("t2_max_inflight", max_infl, MAXF);
      check("t2_push_cnt", push_cnt, 24);
      if (rd_cyc.size() > NPIX && wr_cyc.size() > NPIX - 1)
         check("t2_bwd_after_wr11", rd_cyc[NPIX] > wr_cyc[NPIX-1], 1);
      else
         check("t2_order_sizes", 0, 1);

      // 3: stall while rd_addr=5
      start_run(1, 3);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(bif.rd_en && bif.rd_addr == 5) && n < 200);
      check("t3_reach5", bif.rd_en && bif.rd_addr == 5, 1);
      bif.stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("t3_stall_rd_en[%0d]", i), bif.rd_en, 0);
         check($sformatf("t3_stall_addr[%0d]", i), bif.rd_addr, 5);
      end
      bif.stall = 1'b0;
      @(negedge clk);
      check("t3_resume_en", bif.rd_en, 1);
      check("t3_resume_addr", bif.rd_addr, 6);
      wait_done("t3", 2000);
      repeat (3) @(negedge clk);
      cmp_logs("t3", 1);

      // 4: zero iterations, then three iterations
      start_run(0, 3);
      @(negedge clk);
      check("t4_done_now", bif.done, 1);
      check("t4_busy0", bif.busy, 0);
      @(negedge clk);
      check("t4_done_pulse", bif.done, 0);
      repeat (5) @(negedge clk);
      check("t4_no_rd", rd_q.size(), 0);
      d0 = done_cnt;
      start_run(3, 3);
      wait_done("t4b", 6000);
      repeat (5) @(negedge clk);
      cmp_logs("t4b", 3);
      check("t4b_iter", bif.iter_count, 3);
      check("t4b_busy", bif.busy, 0);
      check("t4b_done_once", done_cnt - d0, 1);

      // 5: reset mid-run at addr 7, stale valid, restart
      start_run(1, 3);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(bif.rd_en && bif.rd_addr == 7) && n < 200);
      check("t5_reach7", bif.rd_en && bif.rd_addr == 7, 1);
      rst = 1'b1;
      #1;
      check("t5_outs_zero", {bif.rd_en, bif.rd_addr, bif.push, bif.sweep_dir, bif.border,
                             bif.wr_en, bif.wr_addr, bif.wr_dir, bif.busy, bif.done,
                             bif.iter_count, bif.error}, 0);
      @(negedge clk);
      rst = 1'b0;
      d0 = done_cnt;
      clear_logs();
      repeat (20) @(negedge clk);
      check("t5_no_done", done_cnt - d0, 0);
      check("t5_no_rd", rd_q.size(), 0);
      inj_valid = 1'b1;
      @(negedge clk);
      inj_valid = 1'b0;
      check("t5_error", bif.error, 1);
      check("t5_wr_en", bif.wr_en, 0);
      check("t5_inflight", dut.inflight_q, 0);
      repeat (3) @(negedge clk);
      check("t5_no_wr", wr_q.size(), 0);
      check("t5_error_sticky", bif.error, 1);
      start_run(1, 3);
      check("t5_error_clr", bif.error, 0);
      wait_done("t5", 2000);
      repeat (3) @(negedge clk);
      cmp_logs("t5", 1);
      check("t5_iter", bif.iter_count, 1);

      // 6: issue and valid together at inflight=3; queue never full+push
      start_run(1, 1);
      wait_done("t6", 2000);
      repeat (3) @(negedge clk);
      cmp_logs("t6", 1);
      check("t6_same_seen", same_seen != 0, 1);
      check("t6_same_hold", same_bad, 0);
      check("t6_fullpush", fullpush, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
